avalon_pio_in_edge: RTL and testbench

// Parametrised Avalon-MM input PIO with metastability synchroniser, per-bit edge capture
// and a maskable level interrupt. Samples asynchronous board inputs (USB GPX/INT lines,

---
 rtl/avalon_pio_in_edge.sv | 110 +++++++++++
 tb/tb_avalon_pio_in_edge.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pio_in_edge.sv
// Avalon-MM input PIO: per-bit metastability synchroniser, sticky edge capture
// (write-1-to-clear) and a maskable level interrupt built from the captured flags.
module avalon_pio_in_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_ENABLE  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;

  logic [WIDTH-1:0] sync_val;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] w1c_vec;
  logic             wr_en;
  logic             wdata_unused;

  // A write is a single-cycle strobe: chipselect=1 and write_n=0 at a rising
  // edge commits the write; there is no waitrequest, so the slave is always ready.
  assign wr_en        = chipselect & ~write_n;
  assign wdata_unused = ^writedata;
  assign sync_val     = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = in_port;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  always_comb begin
    edge_vec = '0;
    case (EDGE_TYPE)
      0:       edge_vec = sync_val & ~prev_q;
      1:       edge_vec = ~sync_val & prev_q;
      default: edge_vec = sync_val ^ prev_q;
    endcase
  end

  always_comb begin
    prev_d    = sync_val;
    w1c_vec   = '0;
    irqmask_d = irqmask_q;
    if (wr_en && (address == ADDR_EDGE)) begin
      w1c_vec = writedata[WIDTH-1:0];
    end
    if (IRQ_ENABLE == 0) begin
      irqmask_d = '0;
    end else if (wr_en && (address == ADDR_MASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    // A new edge overrides a same-cycle clear so no event is ever lost.
    edgecap_d = (edgecap_q & ~w1c_vec) | edge_vec;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = sync_val;
      ADDR_RSVD: readdata_d            = '0;
      ADDR_MASK: readdata_d[WIDTH-1:0] = irqmask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edgecap_q;
      default:   readdata_d            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      prev_q     <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      prev_q     <= prev_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = (IRQ_ENABLE != 0) && (|(edgecap_q & irqmask_q));

endmodule

// File: tb/tb_avalon_pio_in_edge.sv
// Bench for avalon_pio_in_edge: four instances (rising, falling, any edge, irq disabled)
// share one stimulus stream and are checked against a pin-history reference model.
module tb_avalon_pio_in_edge;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int NDUT = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             chipselect = 1'b0;
  logic [1:0]       address = 2'd0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [W-1:0]     in_port = '0;
  logic [31:0]      rd [NDUT];
  logic [NDUT-1:0]  irq_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    avalon_pio_in_edge #(
      .WIDTH(W), .SYNC_STAGES(SYNC),
      .EDGE_TYPE((g == 3) ? 0 : g), .IRQ_ENABLE((g == 3) ? 0 : 1)
    ) dut (
      .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
      .write_n(write_n), .writedata(writedata), .readdata(rd[g]),
      .in_port(in_port), .irq(irq_v[g])
    );
  end

  // Reference model: sync output is the pin sampled SYNC edges ago.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_cap  [NDUT];
  logic [W-1:0] m_mask [NDUT];
  logic [31:0]  m_rd   [NDUT];

  function automatic int etype(int d);
    return (d == 3) ? 0 : d;
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i <= SYNC; i++) hist.push_back('0);
    for (int d = 0; d < NDUT; d++) begin
      m_cap[d] = '0; m_mask[d] = '0; m_rd[d] = '0;
    end
  endfunction

  function automatic void model_clock();
    logic [W-1:0] s, p, e, clr;
    bit wr;
    s  = hist[SYNC-1];
    p  = hist[SYNC];
    wr = chipselect && !write_n;
    clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
    for (int d = 0; d < NDUT; d++) begin
      case (address)
        2'd0: m_rd[d] = 32'(s);
        2'd1: m_rd[d] = 32'h0;
        2'd2: m_rd[d] = 32'(m_mask[d]);
        default: m_rd[d] = 32'(m_cap[d]);
      endcase
      if (etype(d) == 0) e = s & ~p;
      else if (etype(d) == 1) e = ~s & p;
      else e = s ^ p;
      m_cap[d] = (m_cap[d] & ~clr) | e;
      if (wr && address == 2'd2 && d != 3) m_mask[d] = writedata[W-1:0];
    end
    hist.push_front(in_port);
    void'(hist.pop_back());
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("model_rd%0d", d), rd[d], m_rd[d]);
      chk($sformatf("model_irq%0d", d), 32'(irq_v[d]), 32'(|(m_cap[d] & m_mask[d])));
    end
  endtask

  // Called at a negedge; drives inputs, clocks once, checks, returns at next negedge.
  task automatic step(input logic cs, input logic [1:0] a, input logic wn,
                      input logic [31:0] wd, input logic [W-1:0] pin);
    chipselect = cs; address = a; write_n = wn; writedata = wd; in_port = pin;
    @(posedge clk);
    model_clock();
    #1;
    check_model();
    @(negedge clk);
  endtask

  task automatic rd_reg(input logic [1:0] a, input logic [W-1:0] pin);
    step(1'b0, a, 1'b1, 32'h0, pin);
  endtask

  typedef struct {
    logic        cs;
    logic [1:0]  addr;
    logic        wn;
    logic [31:0] wd;
    logic [7:0]  pin;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [21];

  initial begin
    tbl[0]  = '{1'b0, 2'd2, 1'b1, 32'h0,        8'h00, 32'h00, 1'b0};
    tbl[1]  = '{1'b0, 2'd3, 1'b1, 32'h0,        8'h00, 32'h00, 1'b0};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'hFFFFFFFF, 8'h00, 32'h00, 1'b0};
    tbl[3]  = '{1'b0, 2'd2, 1'b1, 32'h0,        8'h00, 32'hFF, 1'b0};
    tbl[4]  = '{1'b0, 2'd1, 1'b1, 32'h0,        8'h00, 32'h00, 1'b0};
    tbl[5]  = '{1'b1, 2'd2, 1'b0, 32'h04,       8'h00, 32'hFF, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 32'h0,        8'h05, 32'h00, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 1'b1, 32'h0,        8'h05, 32'h00, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 1'b1, 32'h0,        8'h05, 32'h05, 1'b1};
    tbl[9]  = '{1'b0, 2'd3, 1'b1, 32'h0,        8'h05, 32'h05, 1'b1};
    tbl[10] = '{1'b1, 2'd3, 1'b0, 32'h04,       8'h05, 32'h05, 1'b0};
    tbl[11] = '{1'b0, 2'd3, 1'b1, 32'h0,        8'h05, 32'h01, 1'b0};
    tbl[12] = '{1'b1, 2'd3, 1'b0, 32'hFFFFFF00, 8'h05, 32'h01, 1'b0};
    tbl[13] = '{1'b0, 2'd3, 1'b1, 32'h0,        8'h05, 32'h01, 1'b0};
    tbl[14] = '{1'b1, 2'd3, 1'b0, 32'h01,       8'h05, 32'h01, 1'b0};
    tbl[15] = '{1'b0, 2'd3, 1'b1, 32'h0,        8'h05, 32'h00, 1'b0};
    tbl[16] = '{1'b1, 2'd0, 1'b0, 32'hFF,       8'h05, 32'h05, 1'b0};
    tbl[17] = '{1'b0, 2'd0, 1'b1, 32'h0,        8'h05, 32'h05, 1'b0};
    tbl[18] = '{1'b1, 2'd1, 1'b0, 32'hFF,       8'h05, 32'h00, 1'b0};
    tbl[19] = '{1'b0, 2'd2, 1'b0, 32'h0,        8'h05, 32'h04, 1'b0};
    tbl[20] = '{1'b0, 2'd2, 1'b1, 32'h0,        8'h05, 32'h04, 1'b0};

    // Reset held while the pins toggle: nothing may leak out.
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_port = W'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
        chk("reset_rd", rd[d], 32'h0);
        chk("reset_irq", 32'(irq_v[d]), 32'h0);
      end
    end
    @(negedge clk);
    in_port = '0;
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].cs, tbl[i].addr, tbl[i].wn, tbl[i].wd, tbl[i].pin);
      chk($sformatf("tbl%0d_rd", i), rd[0], tbl[i].exp_rd);
      chk($sformatf("tbl%0d_irq", i), 32'(irq_v[0]), 32'(tbl[i].exp_irq));
    end

    // Clear collides with a fresh rising edge on bit1.
    step(1'b1, 2'd3, 1'b0, 32'hFF, 8'h05);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b1, 32'h0, 8'h07);
    rd_reg(2'd3, 8'h07);
    chk("bit1_rise_flag", rd[0], 32'h02);
    step(1'b1, 2'd3, 1'b0, 32'h02, 8'h07);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b1, 32'h0, 8'h05);
    step(1'b0, 2'd0, 1'b1, 32'h0, 8'h07);
    step(1'b0, 2'd0, 1'b1, 32'h0, 8'h07);
    step(1'b1, 2'd3, 1'b0, 32'h02, 8'h07);
    rd_reg(2'd3, 8'h07);
    chk("collide_rise", rd[0], 32'h02);
    chk("collide_fall_type", rd[1], 32'h00);
    chk("collide_any_type", rd[2], 32'h02);

    // Bit3 rising then falling across edge types.
    step(1'b1, 2'd3, 1'b0, 32'hFF, 8'h07);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b1, 32'h0, 8'h0F);
    rd_reg(2'd3, 8'h0F);
    chk("b3_rise_t0", rd[0], 32'h08);
    chk("b3_rise_t1", rd[1], 32'h00);
    chk("b3_rise_t2", rd[2], 32'h08);
    step(1'b1, 2'd3, 1'b0, 32'hFF, 8'h0F);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b1, 32'h0, 8'h07);
    rd_reg(2'd3, 8'h07);
    chk("b3_fall_t0", rd[0], 32'h00);
    chk("b3_fall_t1", rd[1], 32'h08);
    chk("b3_fall_t2", rd[2], 32'h08);
    step(1'b1, 2'd2, 1'b0, 32'h08, 8'h07);
    chk("unmask_irq_t1", 32'(irq_v[1]), 32'h1);
    chk("unmask_irq_t0", 32'(irq_v[0]), 32'h0);
    chk("irq_disabled", 32'(irq_v[3]), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom(), ($urandom_range(0, 3) == 0) ? W'($urandom()) : in_port);
    end

    // Asynchronous reset mid-operation.
    #2;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("midreset_rd", rd[d], 32'h0);
      chk("midreset_irq", 32'(irq_v[d]), 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_port = W'($urandom());
      #1;
      chk("midreset_irq_hold", 32'(irq_v[0]), 32'h0);
    end
    @(negedge clk);
    in_port = '0;
    model_reset();
    reset_n = 1'b1;
    rd_reg(2'd2, 8'h00);
    rd_reg(2'd3, 8'h00);
    chk("post_reset_cap", rd[0], 32'h0);
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom(), W'($urandom()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
